ldpc_enc_7_3: RTL and testbench



---
 rtl/ldpc_enc_7_3_if.sv | 30 +++
 rtl/ldpc_enc_7_3.sv | 108 ++++++++++
 tb/tb_ldpc_enc_7_3.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ldpc_enc_7_3_if.sv
// Stream interface for ldpc_enc_7_3: message in, codeword out.
// err_mask exists only when ENC_ERR_INJ_EN is defined.
`timescale 1ns/1ps
interface ldpc_enc_7_3_if;
   logic       in_valid;
   logic       in_ready;
   logic [3:1] msg;
   logic       out_valid;
   logic       out_ready;
   logic [7:1] cw;
`ifdef ENC_ERR_INJ_EN
   logic [7:1] err_mask;
`endif

   modport master (
      output in_valid, msg, out_ready,
`ifdef ENC_ERR_INJ_EN
      output err_mask,
`endif
      input  in_ready, out_valid, cw
   );

   modport slave (
      input  in_valid, msg, out_ready,
`ifdef ENC_ERR_INJ_EN
      input  err_mask,
`endif
      output in_ready, out_valid, cw
   );
endinterface

// File: rtl/ldpc_enc_7_3.sv
// Serial systematic encoder for the 7-bit cyclic LDPC code (c[i]^c[i+1]^c[i+3]=0).
// Optional channel-error injection on the output codeword: define ENC_ERR_INJ_EN.
`timescale 1ns/1ps
module ldpc_enc_7_3 #(
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   ldpc_enc_7_3_if.slave     bus,
   output logic              busy,
   output logic [CNT_W-1:0]  cw_cnt
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state_reg, state_next;
   logic [6:1]         sr_reg, sr_next;
   logic [2:0]         k_reg, k_next;
   logic [7:1]         cw_reg, cw_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [7:4]         par;
   logic [7:1]         inj_mask;

`ifdef ENC_ERR_INJ_EN
   logic [7:1]         mask_reg, mask_next;
   assign inj_mask = mask_reg;
`else
   assign inj_mask = '0;
`endif

   // Recurrence c[k] = c[k-3] ^ c[k-2]; only the bit addressed by k is consumed.
   genvar gi;
   generate
      for (gi = 4; gi <= 7; gi++) begin : g_par
         assign par[gi] = sr_reg[gi-3] ^ sr_reg[gi-2];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         sr_reg    <= '0;
         k_reg     <= '0;
         cw_reg    <= '0;
         cnt_reg   <= '0;
`ifdef ENC_ERR_INJ_EN
         mask_reg  <= '0;
`endif
      end else begin
         state_reg <= state_next;
         sr_reg    <= sr_next;
         k_reg     <= k_next;
         cw_reg    <= cw_next;
         cnt_reg   <= cnt_next;
`ifdef ENC_ERR_INJ_EN
         mask_reg  <= mask_next;
`endif
      end
   end

   always_comb begin
      state_next = state_reg;
      sr_next    = sr_reg;
      k_next     = k_reg;
      cw_next    = cw_reg;
      cnt_next   = cnt_reg;
`ifdef ENC_ERR_INJ_EN
      mask_next  = mask_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (bus.in_valid) begin
               sr_next    = {3'b000, bus.msg};
               k_next     = 3'd4;
`ifdef ENC_ERR_INJ_EN
               mask_next  = bus.err_mask;
`endif
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            for (int i = 4; i <= 6; i++) begin
               if (k_reg == 3'(i)) sr_next[i] = par[i];
            end
            k_next = k_reg + 3'd1;
            // c7 goes straight into the output register together with c1..c6.
            if (k_reg == 3'd7) begin
               cw_next    = {par[7], sr_reg} ^ inj_mask;
               state_next = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               cnt_next   = cnt_reg + CNT_W'(1);
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.in_ready  = (state_reg == IDLE);
   assign bus.out_valid = (state_reg == DONE);
   assign bus.cw        = cw_reg;
   assign busy          = (state_reg != IDLE);
   assign cw_cnt        = cnt_reg;

endmodule

// File: tb/tb_ldpc_enc_7_3.sv
// Self-checking bench for ldpc_enc_7_3: vector table, hand sequences, random words.
// The reference model solves the cyclic parity checks directly by search.
`timescale 1ns/1ps
module tb_ldpc_enc_7_3;
   localparam int TB_CNT_W = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic busy;
   logic [TB_CNT_W-1:0] cw_cnt;

   always #5 clk = ~clk;

   ldpc_enc_7_3_if bus_if ();

   ldpc_enc_7_3 #(.CNT_W(TB_CNT_W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus_if),
      .busy   (busy),
      .cw_cnt (cw_cnt)
   );

   typedef struct {
      logic [3:1] msg;
      logic [7:1] exp_cw;
      int         exp_cnt;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;
   logic [7:1] cur_mask = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Find the unique c4..c7 for which all seven cyclic checks hold.
   function automatic logic [7:1] model_cw(input logic [3:1] m);
      logic [7:1] c;
      logic [7:1] res;
      logic       ok;
      res = '0;
      for (int p = 0; p < 16; p++) begin
         c  = {p[3:0], m};
         ok = 1'b1;
         for (int i = 1; i <= 7; i++) begin
            if (c[i] ^ c[(i % 7) + 1] ^ c[((i + 2) % 7) + 1]) ok = 1'b0;
         end
         if (ok) res = c;
      end
      return res;
   endfunction

   task automatic drive_mask(input logic [7:1] m);
`ifdef ENC_ERR_INJ_EN
      bus_if.err_mask = m;
`else
      if (m != '0) $display("note: mask %b ignored, injection not built", m);
`endif
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after the transfer.
   task automatic run_word(input logic [3:1] m, input int stall, input bit hold_iv,
                           output logic [7:1] got);
      int lat;
      int lowc;
      logic [7:1] exp;
      exp = model_cw(m) ^ cur_mask;
      chk("in_ready_idle", 32'(bus_if.in_ready), 32'd1);
      bus_if.in_valid  = 1'b1;
      bus_if.msg       = m;
      bus_if.out_ready = 1'b0;
      drive_mask(cur_mask);
      @(negedge clk);
      lat  = 0;
      lowc = 0;
      while (!bus_if.out_valid && lat < 20) begin
         if (!bus_if.in_ready) lowc++;
         // Everything here must be ignored while the encoder is shifting.
         bus_if.in_valid  = 1'($urandom);
         bus_if.msg       = 3'($urandom);
         bus_if.out_ready = 1'($urandom);
`ifdef ENC_ERR_INJ_EN
         bus_if.err_mask  = 7'($urandom);
`endif
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'd4);
      chk("cw", 32'(bus_if.cw), 32'(exp));
      chk("busy_done", 32'(busy), 32'd1);
      chk("weight", 32'(($countones(bus_if.cw ^ cur_mask) == 0) ||
                        ($countones(bus_if.cw ^ cur_mask) == 4)), 32'd1);
      got = bus_if.cw;
      if (!bus_if.in_ready) lowc++;
      bus_if.in_valid  = hold_iv;
      bus_if.msg       = hold_iv ? 3'b111 : 3'b000;
      bus_if.out_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         if (!bus_if.in_ready) lowc++;
         chk("stall_cw", 32'(bus_if.cw), 32'(exp));
         chk("stall_valid", 32'(bus_if.out_valid), 32'd1);
         chk("stall_cnt", 32'(cw_cnt), 32'(exp_cnt % (1 << TB_CNT_W)));
      end
      bus_if.out_ready = 1'b1;
      @(negedge clk);
      bus_if.out_ready = 1'b0;
      exp_cnt++;
      chk("in_ready_low_cycles", 32'(lowc), 32'(5 + stall));
      chk("valid_after", 32'(bus_if.out_valid), 32'd0);
      chk("in_ready_after", 32'(bus_if.in_ready), 32'd1);
      chk("cnt", 32'(cw_cnt), 32'(exp_cnt % (1 << TB_CNT_W)));
      $display("word msg=%b stall=%0d cw=%b exp=%b cnt=%0d", m, stall, got, exp, cw_cnt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[5];
      logic [7:1] got;

      tbl[0] = '{3'b001, 7'b1101001, 1};
      tbl[1] = '{3'b010, 7'b0111010, 2};
      tbl[2] = '{3'b100, 7'b1110100, 3};
      tbl[3] = '{3'b111, 7'b0100111, 0};
      tbl[4] = '{3'b000, 7'b0000000, 1};

      rst_n            = 1'b0;
      bus_if.in_valid  = 1'b0;
      bus_if.msg       = '0;
      bus_if.out_ready = 1'b0;
      drive_mask('0);
      #12;
      chk("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cw", 32'(bus_if.cw), 32'd0);
      chk("rst_cnt", 32'(cw_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back vectors; the counter wraps through 1,2,3,0,1.
      for (int v = 0; v < 5; v++) begin
         run_word(tbl[v].msg, 0, 1'b0, got);
         chk("tbl_cw", 32'(got), 32'(tbl[v].exp_cw));
         chk("tbl_cnt", 32'(cw_cnt), 32'(tbl[v].exp_cnt));
      end

      // Stall in DONE with a new request pending, then accept it.
      run_word(3'b001, 10, 1'b1, got);
      chk("hold_cw", 32'(got), 32'(7'b1101001));
      run_word(3'b111, 0, 1'b0, got);
      chk("hold_next_cw", 32'(got), 32'(7'b0100111));

      // Reset during the second SHIFT cycle.
      bus_if.in_valid = 1'b1;
      bus_if.msg      = 3'b001;
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", 32'(bus_if.in_ready), 32'd1);
      chk("mid_rst_out_valid", 32'(bus_if.out_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_cw", 32'(bus_if.cw), 32'd0);
      chk("mid_rst_cnt", 32'(cw_cnt), 32'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      exp_cnt = 0;
      run_word(3'b100, 0, 1'b0, got);
      chk("post_rst_cw", 32'(got), 32'(7'b1110100));
      chk("post_rst_cnt", 32'(cw_cnt), 32'd1);

      // Random words with random stalls.
      for (int r = 0; r < 25; r++) begin
`ifdef ENC_ERR_INJ_EN
         case ($urandom_range(0, 2))
            0:       cur_mask = '0;
            1:       cur_mask = 7'(1 << $urandom_range(0, 6));
            default: cur_mask = 7'(1 << $urandom_range(0, 6)) | 7'(1 << $urandom_range(0, 6));
         endcase
`endif
         run_word(3'($urandom), $urandom_range(0, 3), 1'b0, got);
      end

`ifdef ENC_ERR_INJ_EN
      cur_mask = 7'b0000100;
      run_word(3'b001, 0, 1'b0, got);
      chk("inj_cw", 32'(got), 32'(7'b1101101));
      cur_mask = '0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
